// File: rtl/relu_backward_if.sv
// Sequencing and data bus of the relu_backward unit: run/running control,
// pass configuration, forward/gradient inputs and gated output.
interface relu_backward_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10
);
   logic              running;
   logic              run;
   logic              mode;
   logic [ADDR_W:0]   length;
   logic [DATA_W-1:0] in0;
   logic [DATA_W-1:0] in1;
   logic [DATA_W-1:0] out0;
   logic              done;

   modport master (
      output running, run, mode, length, in0, in1,
      input  out0, done
   );

   modport slave (
      input  running, run, mode, length, in0, in1,
      output out0, done
   );
endinterface

// File: rtl/relu_backward.sv
// ReLU with derivative-mask capture (RECORD) and mask-gated gradient (REPLAY).
// Optional leaky slope on the non-positive path: define RELU_BACKWARD_LEAKY_EN.
module relu_backward #(
   parameter int DATA_W     = 32,
   parameter int DEPTH      = 1024,
   parameter int LEAK_SHIFT = 3
) (
   input  logic           clk,
   input  logic           rst,
   relu_backward_if.slave bus
);
   localparam int              ADDR_W  = $clog2(DEPTH);
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } state_t;

   if (LEAK_SHIFT < 0 || LEAK_SHIFT >= DATA_W) begin : g_bad_leak_shift
      $error("relu_backward: LEAK_SHIFT must lie in [0, DATA_W)");
   end

   state_t            state_q;
   logic [ADDR_W:0]   cnt_q;
   logic [ADDR_W:0]   len_q;
   logic              mode_q;
   logic              done_q;
   logic [DATA_W-1:0] out_q;
   logic [DEPTH-1:0]  mask_q;

   logic [ADDR_W:0]   len_d;
   logic [ADDR_W-1:0] idx;
   logic              pos_in0;
   logic              mask_bit;
   logic              last_sample;
   logic [DATA_W-1:0] rec_out;
   logic [DATA_W-1:0] rep_out;

   assign len_d       = (bus.length > DEPTH_L) ? DEPTH_L : bus.length;
   assign idx         = cnt_q[ADDR_W-1:0];
   // Zero and every negative value (including the most-negative) record 0.
   assign pos_in0     = ~bus.in0[DATA_W-1] & (|bus.in0);
   assign mask_bit    = mask_q[idx];
   assign last_sample = (cnt_q == len_q - 1'b1);

`ifdef RELU_BACKWARD_LEAKY_EN
   assign rec_out = pos_in0  ? bus.in0 : ($signed(bus.in0) >>> LEAK_SHIFT);
   assign rep_out = mask_bit ? bus.in1 : ($signed(bus.in1) >>> LEAK_SHIFT);
`else
   assign rec_out = pos_in0  ? bus.in0 : '0;
   assign rep_out = mask_bit ? bus.in1 : '0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         mode_q  <= 1'b0;
         done_q  <= 1'b0;
         out_q   <= '0;
         mask_q  <= '0;
      end else if (bus.running) begin
         if (bus.run) begin
            // A run in any state (including ACTIVE) restarts the pass without processing a sample.
            mode_q  <= bus.mode;
            len_q   <= len_d;
            cnt_q   <= '0;
            done_q  <= (len_d == '0);
            state_q <= (len_d == '0) ? DONE : ACTIVE;
         end else if (state_q == ACTIVE) begin
            if (mode_q) begin
               out_q <= rep_out;
            end else begin
               out_q       <= rec_out;
               mask_q[idx] <= pos_in0;
            end
            cnt_q <= cnt_q + 1'b1;
            if (last_sample) begin
               state_q <= DONE;
               done_q  <= 1'b1;
            end
         end
      end
   end

   assign bus.out0 = out_q;
   assign bus.done = done_q;
endmodule

// File: tb/tb_relu_backward.sv
// Directed bench for relu_backward: reset, RECORD/REPLAY, stall, length edges, leaky path.
`timescale 1ns/1ps
module tb_relu_backward;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = $clog2(DEPTH);

   logic clk = 1'b0;
   logic rst = 1'b1;

   relu_backward_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   relu_backward #(
      .DATA_W     (DATA_W),
      .DEPTH      (DEPTH),
      .LEAK_SHIFT (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("ok   %s got=%h", tag, got);
      end
   endtask

   // Expected output for a non-positive activation / unmasked gradient.
   function automatic logic [31:0] leak(input logic [31:0] x);
`ifdef RELU_BACKWARD_LEAKY_EN
      return $signed(x) >>> 3;
`else
      return x & 32'd0;
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_pass(input logic m, input logic [ADDR_W:0] len);
      bus.run    = 1'b1;
      bus.mode   = m;
      bus.length = len;
      step();
      bus.run = 1'b0;
   endtask

   logic [31:0] rec_in  [4] = '{32'd5, 32'hFFFF_FFFD, 32'd0, 32'h7FFF_FFFF};
   logic [31:0] rec_exp [4];
   logic [31:0] stl_in  [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
   logic [31:0] stl_exp [4];
   logic [31:0] v;
   logic [31:0] e;

   initial begin
      rec_exp = '{32'd5, leak(32'hFFFF_FFFD), 32'd0, 32'h7FFF_FFFF};
      stl_exp = '{32'h11, leak(32'h22), leak(32'h33), 32'h44};

      bus.running = 1'b1;
      bus.run     = 1'b0;
      bus.mode    = 1'b0;
      bus.length  = '0;
      bus.in0     = '0;
      bus.in1     = '0;

      #2 rst = 1'b0;
      #1;
      check_val("reset_out0", bus.out0, 32'd0);
      check_val("reset_done", {31'd0, bus.done}, 32'd1 & 32'd0);
      #10 rst = 1'b1;
      step();

      // Asynchronous reset in the middle of an ACTIVE pass
      start_pass(1'b0, 5'd4);
      bus.in0 = 32'd5;
      step();
      check_val("midrst_pre_out0", bus.out0, 32'd5);
      #2 rst = 1'b0;
      #1;
      check_val("midrst_out0", bus.out0, 32'd0);
      check_val("midrst_done", {31'd0, bus.done}, 32'd0);
      #1 rst = 1'b1;
      step();
      start_pass(1'b1, 5'd4);
      bus.in1 = 32'h10;
      for (int i = 0; i < 4; i++) begin
         step();
         check_val($sformatf("cleared_replay_%0d", i), bus.out0, leak(32'h10));
      end
      check_val("cleared_replay_done", {31'd0, bus.done}, 32'd1);

      // RECORD of 4 samples
      start_pass(1'b0, 5'd4);
      check_val("rec_done_cleared", {31'd0, bus.done}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         bus.in0 = rec_in[i];
         step();
         check_val($sformatf("rec_out_%0d", i), bus.out0, rec_exp[i]);
         check_val($sformatf("rec_done_%0d", i), {31'd0, bus.done}, (i == 3) ? 32'd1 : 32'd0);
      end
      bus.in0 = 32'd9;
      step();
      step();
      check_val("rec_out_hold", bus.out0, 32'h7FFF_FFFF);
      check_val("rec_done_hold", {31'd0, bus.done}, 32'd1);

      // Zero-length pass finishes immediately and leaves the mask alone
      start_pass(1'b0, 5'd0);
      check_val("len0_done", {31'd0, bus.done}, 32'd1);
      check_val("len0_out_hold", bus.out0, 32'h7FFF_FFFF);

      // REPLAY of the recorded mask
      start_pass(1'b1, 5'd4);
      bus.in1 = 32'h100;
      for (int i = 0; i < 4; i++) begin
         step();
         e = (i == 0 || i == 3) ? 32'h100 : leak(32'h100);
         check_val($sformatf("rep_out_%0d", i), bus.out0, e);
         check_val($sformatf("rep_done_%0d", i), {31'd0, bus.done}, (i == 3) ? 32'd1 : 32'd0);
      end
      step();
      step();
      check_val("rep_done_hold", {31'd0, bus.done}, 32'd1);

      // REPLAY with a 3-cycle stall after the first sample
      start_pass(1'b1, 5'd4);
      bus.in1 = stl_in[0];
      step();
      check_val("stall_out_0", bus.out0, stl_exp[0]);
      bus.running = 1'b0;
      bus.in1     = 32'h99;
      for (int i = 0; i < 3; i++) begin
         step();
         check_val($sformatf("stall_frozen_out_%0d", i), bus.out0, stl_exp[0]);
         check_val($sformatf("stall_frozen_done_%0d", i), {31'd0, bus.done}, 32'd0);
      end
      bus.running = 1'b1;
      for (int i = 1; i < 4; i++) begin
         bus.in1 = stl_in[i];
         step();
         check_val($sformatf("stall_out_%0d", i), bus.out0, stl_exp[i]);
         check_val($sformatf("stall_done_%0d", i), {31'd0, bus.done}, (i == 3) ? 32'd1 : 32'd0);
      end

      // Length above DEPTH is clamped to DEPTH
      start_pass(1'b0, 5'(DEPTH + 5));
      for (int i = 0; i < DEPTH; i++) begin
         v = (i % 2 == 0) ? 32'(i + 1) : -32'(i + 1);
         bus.in0 = v;
         step();
         e = (i % 2 == 0) ? v : leak(v);
         check_val($sformatf("clamp_rec_%0d", i), bus.out0, e);
         check_val($sformatf("clamp_done_%0d", i), {31'd0, bus.done}, (i == DEPTH - 1) ? 32'd1 : 32'd0);
      end
      bus.in0 = 32'd77;
      step();
      check_val("clamp_out_hold", bus.out0, leak(-32'(DEPTH)));
      start_pass(1'b1, 5'(DEPTH));
      for (int i = 0; i < DEPTH; i++) begin
         bus.in1 = 32'h40 + 32'(i);
         step();
         e = (i % 2 == 0) ? 32'h40 + 32'(i) : leak(32'h40 + 32'(i));
         check_val($sformatf("clamp_rep_%0d", i), bus.out0, e);
      end

      // Leaky slope (0 when the feature is compiled out)
      start_pass(1'b0, 5'd1);
      bus.in0 = 32'hFFFF_FFF0;
      step();
`ifdef RELU_BACKWARD_LEAKY_EN
      check_val("leaky_rec", bus.out0, 32'hFFFF_FFFE);
`else
      check_val("leaky_rec", bus.out0, 32'd0);
`endif
      start_pass(1'b1, 5'd1);
      bus.in1 = 32'd64;
      step();
`ifdef RELU_BACKWARD_LEAKY_EN
      check_val("leaky_rep", bus.out0, 32'd8);
`else
      check_val("leaky_rep", bus.out0, 32'd0);
`endif
      check_val("leaky_done", {31'd0, bus.done}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
